csr_timer: RTL

CSR_TIMER -- requirements
Module: csr_timer

---
 rtl/csr_timer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/csr_timer.sv
// CSR-mapped countdown timer with free-running stable counter and timer ID.
// Interrupt and clear pulses are registered one-cycle strobes to the exception stage.
module csr_timer #(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_rhit,
  output logic        ti_in,
  output logic        ti_clr,
  output logic [63:0] stable_cnt,
  output logic [31:0] tid
);

  localparam logic [13:0] ADDR_TID   = 14'h40;
  localparam logic [13:0] ADDR_TCFG  = 14'h41;
  localparam logic [13:0] ADDR_TVAL  = 14'h42;
  localparam logic [13:0] ADDR_TICLR = 14'h44;

  logic [63:0]        stable_cnt_q, stable_cnt_d;
  logic [31:0]        tid_q, tid_d;
  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic [TIMER_W-3:0] initval_q, initval_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               armed_q, armed_d;
  logic               pending_q, pending_d;
  logic               ti_in_q, ti_in_d;
  logic               ti_clr_q, ti_clr_d;

  logic wr_tid, wr_tcfg, wr_ticlr;
  logic expiry, irq_want;

  assign wr_tid   = csr_we && (csr_waddr == ADDR_TID);
  assign wr_tcfg  = csr_we && (csr_waddr == ADDR_TCFG);
  assign wr_ticlr = csr_we && (csr_waddr == ADDR_TICLR);

  // A TCFG write in the same cycle suppresses expiry so the new config wins.
  assign expiry = en_q && armed_q && (tval_q == '0) && !wr_tcfg;

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    stable_cnt_d = stable_cnt_q + 64'd1;
    tid_d        = tid_q;
    en_d         = en_q;
    periodic_d   = periodic_q;
    initval_d    = initval_q;
    tval_d       = tval_q;
    armed_d      = armed_q;

    if (wr_tid) tid_d = csr_wdata;

    if (wr_tcfg) begin
      en_d       = csr_wdata[0];
      periodic_d = csr_wdata[1];
      initval_d  = csr_wdata[TIMER_W-1:2];
      if (csr_wdata[0]) begin
        tval_d  = {csr_wdata[TIMER_W-1:2], 2'b00};
        armed_d = 1'b1;
      end else begin
        armed_d = 1'b0;
      end
    end else if (expiry) begin
      if (periodic_q) tval_d  = {initval_q, 2'b00};
      else            armed_d = 1'b0;
    end else if (en_q && (tval_q != '0)) begin
      tval_d = tval_q - TIMER_W'(1);
    end
  end

  // A clear pulse wins the cycle; a coinciding interrupt is held one cycle in pending.
  always_comb begin
    ti_clr_d  = wr_ticlr && csr_wdata[0];
    irq_want  = expiry || pending_q;
    ti_in_d   = irq_want && !ti_clr_d;
    pending_d = irq_want && ti_clr_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt_q <= '0;
      tid_q        <= TID_RST;
      en_q         <= 1'b0;
      periodic_q   <= 1'b0;
      initval_q    <= '0;
      tval_q       <= '0;
      armed_q      <= 1'b0;
      pending_q    <= 1'b0;
      ti_in_q      <= 1'b0;
      ti_clr_q     <= 1'b0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      tid_q        <= tid_d;
      en_q         <= en_d;
      periodic_q   <= periodic_d;
      initval_q    <= initval_d;
      tval_q       <= tval_d;
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      ti_in_q      <= ti_in_d;
      ti_clr_q     <= ti_clr_d;
    end
  end

  // Reads see only registered state, so a same-cycle write is not visible yet.
  always_comb begin
    csr_rdata = 32'h0;
    csr_rhit  = 1'b0;
    case (csr_raddr)
      ADDR_TID: begin
        csr_rdata = tid_q;
        csr_rhit  = 1'b1;
      end
      ADDR_TCFG: begin
        csr_rdata = 32'({initval_q, periodic_q, en_q});
        csr_rhit  = 1'b1;
      end
      ADDR_TVAL: begin
        csr_rdata = 32'(tval_q);
        csr_rhit  = 1'b1;
      end
      ADDR_TICLR: begin
        csr_rhit  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ti_in      = ti_in_q;
  assign ti_clr     = ti_clr_q;
  assign stable_cnt = stable_cnt_q;
  assign tid        = tid_q;

endmodule
